// File: rtl/fc1_dot_accumulator.sv
// ---------------------------------------------------------------------------
// fc1_dot_accumulator
//
// Joins an activation stream and a weight stream beat by beat, multiplies the
// lanes elementwise, sums the lane products (psum) and accumulates psum over
// IN_DEPTH beats. The finished dot product is written to an output register so
// the next accumulation can continue while the result waits downstream.
// The result is full precision: nothing is rounded, shifted or saturated.
// Its fractional bit count is the sum of the activation and weight
// fractional bit counts.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active low (0 = reset)
//   data_in         in   PARALLELISM activation lanes, signed
//   data_in_valid   in   activation beat valid
//   data_in_ready   out  activation beat accepted (needs weight_valid)
//   weight          in   PARALLELISM weight lanes, signed
//   weight_valid    in   weight beat valid
//   weight_ready    out  weight beat accepted (needs data_in_valid)
//   data_out        out  accumulated dot product, DATA_OUT_PRECISION_0 bits
//   data_out_valid  out  result valid
//   data_out_ready  in   downstream accepts the result
// ---------------------------------------------------------------------------
module fc1_dot_accumulator #(
    parameter int DATA_IN_PRECISION_0 = 16,
    parameter int DATA_IN_PRECISION_1 = 3,
    parameter int WEIGHT_PRECISION_0  = 16,
    parameter int WEIGHT_PRECISION_1  = 3,
    parameter int PARALLELISM         = 1,
    parameter int IN_DEPTH            = 32,
    localparam int DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0
                                        + $clog2(PARALLELISM) + $clog2(IN_DEPTH),
    localparam int DATA_OUT_PRECISION_1 = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0]     data_in,
    input  logic                                                data_in_valid,
    output logic                                                data_in_ready,
    input  logic [PARALLELISM-1:0][WEIGHT_PRECISION_0-1:0]      weight,
    input  logic                                                weight_valid,
    output logic                                                weight_ready,
    output logic [DATA_OUT_PRECISION_0-1:0]                     data_out,
    output logic                                                data_out_valid,
    input  logic                                                data_out_ready
);

    localparam int ACC_W = DATA_OUT_PRECISION_0;
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

    // Configuration sanity checks, evaluated at elaboration.
    if (PARALLELISM < 1 || IN_DEPTH < 1) begin : g_bad_shape
        $error("fc1_dot_accumulator: PARALLELISM and IN_DEPTH must be >= 1");
    end
    if (DATA_OUT_PRECISION_1 >= DATA_OUT_PRECISION_0) begin : g_bad_frac
        $error("fc1_dot_accumulator: fractional bits must be fewer than the result width");
    end

    // Sign extension of each operand to the full result width before the
    // multiply, so products and sums cannot overflow.
    function automatic logic signed [ACC_W-1:0] sext_act(
        input logic [DATA_IN_PRECISION_0-1:0] v
    );
        return ACC_W'($signed(v));
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_wgt(
        input logic [WEIGHT_PRECISION_0-1:0] v
    );
        return ACC_W'($signed(v));
    endfunction

    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  data_out_q, data_out_d;
    logic                     data_out_valid_q, data_out_valid_d;

    logic                     last_beat;
    logic                     stall;
    logic                     in_ok;
    logic                     fire;
    logic signed [ACC_W-1:0]  psum;

    assign last_beat = (count_q == LAST_BEAT);

    // Only the final beat needs the output register; earlier beats may
    // proceed while a result is still held.
    assign stall = data_out_valid_q & ~data_out_ready & last_beat;
    assign in_ok = ~stall;

    // Join: neither stream is consumed without the other.
    assign data_in_ready = in_ok & weight_valid;
    assign weight_ready  = in_ok & data_in_valid;
    assign fire          = data_in_valid & weight_valid & in_ok;

    always_comb begin
        psum = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            psum = psum + sext_act(data_in[i]) * sext_wgt(weight[i]);
        end
    end

    always_comb begin
        count_d          = count_q;
        acc_d            = acc_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;

        if (data_out_valid_q && data_out_ready) begin
            data_out_valid_d = 1'b0;
        end

        if (fire) begin
            if (last_beat) begin
                // A final beat in the same cycle as a drain reloads and keeps
                // valid high.
                data_out_d       = acc_q + psum;
                data_out_valid_d = 1'b1;
                acc_d            = '0;
                count_d          = '0;
            end else begin
                acc_d   = acc_q + psum;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q          <= '0;
            acc_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            count_q          <= count_d;
            acc_q            <= acc_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

endmodule

// File: doc/fc1_dot_accumulator.md
# fc1_dot_accumulator

Downstream consumer of the fc1 weight stream. It joins an activation stream and a weight stream beat-by-beat over valid/ready, multiplies the lanes elementwise and sums them, then accumulates over IN_DEPTH beats to produce one full-precision dot-product result per output element. Each result is held in an output register, so the next accumulation can proceed while the result waits for the downstream stage.

## Interface
- DATA_IN_PRECISION_0, 16, activation total width (signed two's complement)
- DATA_IN_PRECISION_1, 3, activation fractional bits
- WEIGHT_PRECISION_0, 16, weight total width (signed)
- WEIGHT_PRECISION_1, 3, weight fractional bits
- PARALLELISM, 1, lanes per beat on both input streams (≥1)
- IN_DEPTH, 32, beats accumulated per result (≥1)
- DATA_OUT_PRECISION_0, DATA_IN_PRECISION_0+WEIGHT_PRECISION_0+$clog2(PARALLELISM)+$clog2(IN_DEPTH), result width; derived, not to be overridden
- DATA_OUT_PRECISION_1, DATA_IN_PRECISION_1+WEIGHT_PRECISION_1, result fractional bits; derived
- clk  in  1  single clock, rising edge
- rst  in  1  reset; **asynchronous, active-low** (0 = reset asserted)
- data_in  in  [DATA_IN_PRECISION_0-1:0] x PARALLELISM  activation lanes
- data_in_valid  in  1  activation beat valid
- data_in_ready  out  1  activation beat accepted
- weight  in  [WEIGHT_PRECISION_0-1:0] x PARALLELISM  weight lanes
- weight_valid  in  1  weight beat valid
- weight_ready  out  1  weight beat accepted
- data_out  out  [DATA_OUT_PRECISION_0-1:0]  accumulated dot product
- data_out_valid  out  1  result valid
- data_out_ready  in  1  downstream accepts result

## Operation
- Internal state:
  - beat counter `count`, range 0..IN_DEPTH-1
  - signed accumulator `acc`, DATA_OUT_PRECISION_0 wide
  - output register `data_out`
  - flag `data_out_valid`
- Intake gating:
  - `stall` = data_out_valid & ~data_out_ready & (count == IN_DEPTH-1)
  - `in_ok` = ~stall
- Join logic:
  - data_in_ready = in_ok & weight_valid
  - weight_ready = in_ok & data_in_valid
  - fire = data_in_valid & weight_valid & in_ok
  - Neither stream is consumed without the other.
- psum: the combinational sum over lanes of data_in[i]*weight[i].
  - Operands are sign-extended to DATA_OUT_PRECISION_0 before multiplying and summing.
  - Fixed-point alignment is implicit: fractional bits add, with no shifting.
  - No rounding and no saturation; the width is sized so overflow is impossible.
- On fire with count < IN_DEPTH-1: acc <= acc + psum; count <= count + 1.
- On fire with count == IN_DEPTH-1:
  - data_out <= acc + psum; data_out_valid <= 1
  - acc <= 0; count <= 0
- data_out_valid clears on data_out_ready & data_out_valid, unless a final beat fires in the same cycle. In that case the new result loads and valid stays 1.
- Non-final beats may be accepted while a result is held. Only the final beat of the next result is blocked until the held result drains.
- IN_DEPTH = 1: every beat is final. Intake is stalled whenever a result is held and data_out_ready = 0.
- data_out holds its value while data_out_valid & ~data_out_ready. Upstream must not see a result change before it is accepted.

## Timing
- Reset (rst = 0, asynchronous):
  - count = 0, acc = 0, data_out = 0, data_out_valid = 0
  - Readies are combinational, so they follow the input valids and stall = 0.
- Reset deassertion is sampled synchronously by the registers. The first beat can fire on the first rising edge with rst = 1.
- Reset mid-accumulation discards the partial sum and any held result.
- Throughput: one beat per cycle when both valids are high and no stall.
- Latency: final beat fires at edge t; data_out_valid = 1 and the result are visible after edge t, i.e. one cycle.
- Multiply/sum is single-cycle combinational; no internal pipeline beyond acc and the output register.
- No combinational path from data_out_ready to data_out.
- The only combinational ready path is data_out_ready → stall → data_in_ready/weight_ready. This is acceptable because the upstream weight source registers its ready usage.

## Test plan
- **Basic accumulation.** PARALLELISM=1, IN_DEPTH=4, 16/3 formats, both streams always valid, data_in=8 (1.0), weight=16 (2.0), data_out_ready=1.
  - Expect data_out=512 (8.0 at 6 fractional bits) with data_out_valid pulsed one cycle after each 4th beat.
  - Expect back-to-back results every 4 cycles.
- **Signed values.** data_in=-8, weight=16, IN_DEPTH=4.
  - Expect data_out=-512, correctly sign-extended to 34 bits.
  - Mixed signs per lane with PARALLELISM=2: {8,-8}×{16,16} gives 0 per beat, so the result is 0.
- **Join.** weight_valid held 0 for 3 cycles while data_in_valid=1.
  - Expect data_in_ready=0 and no count advance.
  - Result is unchanged vs. the uninterrupted run; no beat lost or duplicated.
- **Backpressure.** data_out_ready=0 after the first result.
  - Expect 3 further beats accepted, then both readies low at count=3.
  - data_out stays 512 and stable.
  - Raising data_out_ready gives a simultaneous drain and load; valid stays high with the new result.
- **Reset.** Assert rst=0 mid-accumulation at count=2 and while a result is held.
  - Expect data_out_valid=0 and data_out=0 immediately (asynchronously).
  - After release, the next result counts a full 4 fresh beats.
- **Edge: IN_DEPTH=1** with random data_out_ready.
  - Each accepted beat produces exactly one result equal to its psum.
  - No results are dropped; the sequence matches a scoreboard.
